udm_accel_bridge: RTL and testbench

// Bus slave between udm master port and one HLS accelerator (ap_ctrl_hs) with NUM_BANKS

---
 rtl/udm_accel_bridge.sv | 236 +++++++++++++++++++++++
 tb/tb_udm_accel_bridge.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/udm_accel_bridge.sv
// udm bus slave bridging one ap_ctrl_hs accelerator: CSR window, NUM_BANKS data banks, run guard.
// Optional busy-cycle counter at CSR +0x8 is built only when UDM_ACCEL_CYCCNT_EN is defined.
module udm_accel_bridge #(
  parameter int          NUM_BANKS   = 2,
  parameter int          BANK_AW     = 10,
  parameter logic [31:0] CSR_BASE    = 32'h0000_0000,
  parameter logic [31:0] MEM_BASE    = 32'h8000_0000,
  parameter logic [31:0] BANK_STRIDE = 32'h1000_0000
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    bus_req_i,
  input  logic                    bus_we_i,
  input  logic [31:0]             bus_addr_bi,
  input  logic [3:0]              bus_be_bi,
  input  logic [31:0]             bus_wdata_bi,
  output logic                    bus_ack_o,
  output logic                    bus_resp_o,
  output logic [31:0]             bus_rdata_bo,
  output logic [NUM_BANKS-1:0]    mem_we_bo,
  output logic [BANK_AW-1:0]      mem_addr_bo,
  output logic [31:0]             mem_wdata_bo,
  input  logic [32*NUM_BANKS-1:0] mem_rdata_bi,
  output logic                    ap_start_o,
  input  logic                    ap_ready_i,
  input  logic                    ap_done_i,
  input  logic                    ap_idle_i
);

  localparam int          SELW       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [32:0] BANK_BYTES = 33'd4 << BANK_AW;

  logic                 r_rd_pend;
  logic                 r_s1_bank;
  logic                 r_s1_guard;
  logic [SELW-1:0]      r_s1_sel;
  logic                 r_resp;
  logic                 r_resp_bank;
  logic                 r_resp_guard;
  logic [SELW-1:0]      r_resp_sel;
  logic [31:0]          r_rdata;
  logic [NUM_BANKS-1:0] r_mem_we;
  logic [BANK_AW-1:0]   r_mem_addr;
  logic [31:0]          r_mem_wdata;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic                 r_ap_start;

  logic                 w_accept;
  logic                 w_wr;
  logic                 w_rd;
  logic [31:0]          w_csr_off;
  logic                 w_csr_hit;
  logic                 w_bank_hit;
  logic [SELW-1:0]      w_bank_idx;
  logic                 w_ctrl_wr;
  logic                 w_start;
  logic                 w_clear;
  logic                 w_bank_wr;
  logic                 w_bank_rd;
  logic [NUM_BANKS-1:0] w_we_vec;
  logic [31:0]          w_csr_rdata;
  logic [31:0]          w_bank_rdata;
  logic [31:0]          w_cyc;
  logic                 w_unused;

  assign w_unused  = &{1'b0, bus_be_bi};
  // Gating with rstn_i keeps a request from being acknowledged and then lost to reset.
  assign w_accept  = bus_req_i & ~r_rd_pend & rstn_i;
  assign w_wr      = w_accept & bus_we_i;
  assign w_rd      = w_accept & ~bus_we_i;
  assign w_csr_off = bus_addr_bi - CSR_BASE;
  assign w_csr_hit = (w_csr_off < 32'd16);
  assign w_ctrl_wr = w_wr & w_csr_hit & (w_csr_off[3:2] == 2'd0);
  assign w_start   = w_ctrl_wr & bus_wdata_bi[0];
  assign w_clear   = w_ctrl_wr & bus_wdata_bi[1];
  assign w_bank_wr = w_wr & ~w_csr_hit & w_bank_hit;
  assign w_bank_rd = w_rd & ~w_csr_hit & w_bank_hit;

  always_comb begin : p_bank_dec
    logic [31:0] w_off;
    w_bank_hit = 1'b0;
    w_bank_idx = '0;
    w_off      = 32'd0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      w_off = bus_addr_bi - MEM_BASE - (32'(k) * BANK_STRIDE);
      if ({1'b0, w_off} < BANK_BYTES) begin
        w_bank_hit = 1'b1;
        w_bank_idx = SELW'(k);
      end else begin
        w_bank_idx = w_bank_idx;
      end
    end
  end

  always_comb begin
    w_we_vec = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      w_we_vec[k] = w_bank_wr & ~r_busy & (w_bank_idx == SELW'(k));
    end
  end

  always_comb begin
    w_csr_rdata = 32'd0;
    case (w_csr_off[3:2])
      2'd0:    w_csr_rdata = 32'd0;
      2'd1:    w_csr_rdata = {28'd0, r_err, ap_idle_i, r_done, r_busy};
      2'd2:    w_csr_rdata = w_cyc;
      2'd3:    w_csr_rdata = {16'hACB1, 8'd0, 8'(NUM_BANKS)};
      default: w_csr_rdata = 32'd0;
    endcase
  end

`ifdef UDM_ACCEL_CYCCNT_EN
  logic [31:0] r_cyc;

  // Busy-cycle count of the current or last run, saturating.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_cyc <= 32'd0;
    end else if (w_start & ~r_busy) begin
      r_cyc <= 32'd0;
    end else if (r_busy & (r_cyc != 32'hFFFF_FFFF)) begin
      r_cyc <= r_cyc + 32'd1;
    end else begin
      r_cyc <= r_cyc;
    end
  end

  assign w_cyc = r_cyc;
`else
  assign w_cyc = 32'd0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_ap_start <= 1'b0;
    end else begin
      if (w_clear) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end
      if (r_busy & (w_start | w_bank_wr)) begin
        r_err <= 1'b1;
      end
      if (ap_done_i) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
      if (w_start & ~r_busy) begin
        r_busy     <= 1'b1;
        r_ap_start <= 1'b1;
      end else if (r_ap_start & ap_ready_i) begin
        r_ap_start <= 1'b0;
      end
    end
  end

  // Bank reads take two stages (address out, then sync RAM data); CSR/unmapped reads take one.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_rd_pend    <= 1'b0;
      r_s1_bank    <= 1'b0;
      r_s1_guard   <= 1'b0;
      r_s1_sel     <= '0;
      r_resp       <= 1'b0;
      r_resp_bank  <= 1'b0;
      r_resp_guard <= 1'b0;
      r_resp_sel   <= '0;
      r_rdata      <= 32'd0;
      r_mem_we     <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'd0;
    end else begin
      r_mem_we     <= w_we_vec;
      r_resp       <= 1'b0;
      r_resp_bank  <= 1'b0;
      r_resp_guard <= 1'b0;
      r_rdata      <= 32'd0;
      r_s1_bank    <= 1'b0;
      if (w_bank_wr | w_bank_rd) begin
        r_mem_addr <= bus_addr_bi[BANK_AW+1:2];
      end
      if (w_bank_wr) begin
        r_mem_wdata <= bus_wdata_bi;
      end
      if (w_rd) begin
        r_rd_pend <= 1'b1;
      end else if (r_resp) begin
        r_rd_pend <= 1'b0;
      end
      if (w_bank_rd) begin
        r_s1_bank  <= 1'b1;
        r_s1_guard <= r_busy;
        r_s1_sel   <= w_bank_idx;
      end else if (w_rd) begin
        r_resp  <= 1'b1;
        r_rdata <= w_csr_hit ? w_csr_rdata : 32'd0;
      end
      if (r_s1_bank) begin
        r_resp       <= 1'b1;
        r_resp_bank  <= 1'b1;
        r_resp_guard <= r_s1_guard;
        r_resp_sel   <= r_s1_sel;
      end
    end
  end

  always_comb begin
    w_bank_rdata = 32'd0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (r_resp_sel == SELW'(k)) begin
        w_bank_rdata = mem_rdata_bi[32*k +: 32];
      end else begin
        w_bank_rdata = w_bank_rdata;
      end
    end
    if (r_resp_bank) begin
      bus_rdata_bo = r_resp_guard ? 32'hDEAD_BEEF : w_bank_rdata;
    end else begin
      bus_rdata_bo = r_rdata;
    end
  end

  assign bus_ack_o    = w_accept;
  assign bus_resp_o   = r_resp;
  assign mem_we_bo    = r_mem_we;
  assign mem_addr_bo  = r_mem_addr;
  assign mem_wdata_bo = r_mem_wdata;
  assign ap_start_o   = r_ap_start;

endmodule

// File: tb/tb_udm_accel_bridge.sv
// Directed, table-driven bench for udm_accel_bridge with two behavioural sync-read banks.
module tb_udm_accel_bridge;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [3:0]  be = 4'hF;
  logic [31:0] wdata = 32'd0;
  logic        ack, resp;
  logic [31:0] rdata;
  logic [1:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] ram_rd [2];
  logic [63:0] mem_rdata;
  logic        ap_start;
  logic        ap_ready = 1'b0;
  logic        ap_done = 1'b0;
  logic        ap_idle = 1'b1;

  logic [31:0] ram [2][1024];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  udm_accel_bridge dut (
    .clk_i(clk), .rstn_i(rstn), .bus_req_i(req), .bus_we_i(we),
    .bus_addr_bi(addr), .bus_be_bi(be), .bus_wdata_bi(wdata),
    .bus_ack_o(ack), .bus_resp_o(resp), .bus_rdata_bo(rdata),
    .mem_we_bo(mem_we), .mem_addr_bo(mem_addr), .mem_wdata_bo(mem_wdata),
    .mem_rdata_bi(mem_rdata), .ap_start_o(ap_start),
    .ap_ready_i(ap_ready), .ap_done_i(ap_done), .ap_idle_i(ap_idle)
  );

  assign mem_rdata = {ram_rd[1], ram_rd[0]};

  // Two single-port sync-read RAMs standing in for ram_dual port 0.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_we[k]) ram[k][mem_addr] <= mem_wdata;
      ram_rd[k] <= ram[k][mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output int lat, output logic [1:0] mwe,
                      output logic [9:0] maddr, output logic [31:0] mwd);
    int n;
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; wdata = d;
    n = 0;
    @(negedge clk);
    while (!ack && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!ack) chk("ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    @(negedge clk);
    mwe = mem_we; maddr = mem_addr; mwd = mem_wdata;
    lat = 0; rd = 32'd0;
    for (int c = 1; c <= 4; c++) begin
      if (resp && lat == 0) begin
        lat = c;
        rd = rdata;
      end
      if (c < 4) @(negedge clk);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd, mwd; int lat; logic [1:0] mwe; logic [9:0] ma;
    xfer(1'b1, a, d, rd, lat, mwe, ma, mwd);
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp, input int exp_lat);
    logic [31:0] rd, mwd; int lat; logic [1:0] mwe; logic [9:0] ma;
    xfer(1'b0, a, 32'd0, rd, lat, mwe, ma, mwd);
    chk({nm, "_rdata"}, rd, exp);
    chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    int          lat;
    logic [1:0]  mwe;
    logic [9:0]  maddr;
  } vec_t;

  vec_t tbl [23];

  initial begin
    logic [31:0] rd, mwd;
    int lat, cnt;
    logic [1:0] mwe;
    logic [9:0] ma;

    tbl[0]  = '{1'b1, 32'h8000_0010, 32'h1234_5678, 0, 2'b01, 10'd4};
    tbl[1]  = '{1'b0, 32'h8000_0010, 32'h1234_5678, 2, 2'b00, 10'd0};
    tbl[2]  = '{1'b1, 32'h9000_0000, 32'h0000_0005, 0, 2'b10, 10'd0};
    tbl[3]  = '{1'b1, 32'h8000_0000, 32'hCAFE_0001, 0, 2'b01, 10'd0};
    tbl[4]  = '{1'b0, 32'h8000_0000, 32'hCAFE_0001, 2, 2'b00, 10'd0};
    tbl[5]  = '{1'b0, 32'h9000_0000, 32'h0000_0005, 2, 2'b00, 10'd0};
    tbl[6]  = '{1'b0, 32'h8000_0010, 32'h1234_5678, 2, 2'b00, 10'd0};
    tbl[7]  = '{1'b0, 32'hA000_0000, 32'h0000_0000, 1, 2'b00, 10'd0};
    tbl[8]  = '{1'b1, 32'hA000_0000, 32'h0000_FFFF, 0, 2'b00, 10'd0};
    tbl[9]  = '{1'b0, 32'h0000_000C, 32'hACB1_0002, 1, 2'b00, 10'd0};
    tbl[10] = '{1'b0, 32'h0000_0004, 32'h0000_0004, 1, 2'b00, 10'd0};
    tbl[11] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1, 2'b00, 10'd0};
    tbl[12] = '{1'b0, 32'h0000_0008, 32'h0000_0000, 1, 2'b00, 10'd0};
    tbl[13] = '{1'b1, 32'h8000_0FFC, 32'hA5A5_A5A5, 0, 2'b01, 10'h3FF};
    tbl[14] = '{1'b0, 32'h8000_0FFC, 32'hA5A5_A5A5, 2, 2'b00, 10'd0};
    tbl[15] = '{1'b1, 32'h8000_1000, 32'hDEAD_0000, 0, 2'b00, 10'd0};
    tbl[16] = '{1'b0, 32'h8000_1000, 32'h0000_0000, 1, 2'b00, 10'd0};
    tbl[17] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1, 2'b00, 10'd0};
    tbl[18] = '{1'b1, 32'h9000_0FFC, 32'h7777_0001, 0, 2'b10, 10'h3FF};
    tbl[19] = '{1'b0, 32'h9000_0FFC, 32'h7777_0001, 2, 2'b00, 10'd0};
    tbl[20] = '{1'b0, 32'h8000_0FFC, 32'hA5A5_A5A5, 2, 2'b00, 10'd0};
    tbl[21] = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 0, 2'b00, 10'd0};
    tbl[22] = '{1'b0, 32'h0000_0004, 32'h0000_0004, 1, 2'b00, 10'd0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ap_start", {31'd0, ap_start}, 32'd0);
    chk("rst_resp", {31'd0, resp}, 32'd0);
    chk("rst_mem_we", {30'd0, mem_we}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    @(posedge clk); #1 rstn = 1'b1;

    for (int i = 0; i < 23; i++) begin
      xfer(tbl[i].w, tbl[i].a, tbl[i].d, rd, lat, mwe, ma, mwd);
      chk($sformatf("v%0d_mem_we", i), {30'd0, mwe}, {30'd0, tbl[i].mwe});
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      if (!tbl[i].w) chk($sformatf("v%0d_rdata", i), rd, tbl[i].d);
      if (tbl[i].mwe != 2'b00) begin
        chk($sformatf("v%0d_mem_addr", i), {22'd0, ma}, {22'd0, tbl[i].maddr});
        chk($sformatf("v%0d_mem_wdata", i), mwd, tbl[i].d);
      end
    end

    // Run: ap_ready three cycles after start rises, ap_done in the 20th busy cycle
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 32'h0; wdata = 32'h1;
    @(negedge clk);
    chk("run_ack", {31'd0, ack}, 32'd1);
    cnt = 0;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      req = 1'b0; we = 1'b0;
      ap_ready = (c == 4);
      ap_done  = (c == 20);
      ap_idle  = (c > 20);
      @(negedge clk);
      if (ap_start) cnt++;
      if (c == 1) chk("run_start_next", {31'd0, ap_start}, 32'd1);
    end
    ap_ready = 1'b0; ap_done = 1'b0;
    chk("run_start_cycles", 32'(cnt), 32'd4);
    rd_chk("run_status", 32'h4, 32'h6, 1);
`ifdef UDM_ACCEL_CYCCNT_EN
    rd_chk("run_cycles", 32'h8, 32'd20, 1);
`else
    rd_chk("run_cycles", 32'h8, 32'd0, 1);
`endif

    // Start while busy, guarded bank access, clear
    wr(32'h0, 32'h2);
    ap_idle = 1'b0;
    wr(32'h0, 32'h1);
    rd_chk("busy_status", 32'h4, 32'h1, 1);
    wr(32'h0, 32'h1);
    xfer(1'b1, 32'h8000_0000, 32'h1111_1111, rd, lat, mwe, ma, mwd);
    chk("guard_mem_we", {30'd0, mwe}, 32'd0);
    rd_chk("guard_read", 32'h8000_0000, 32'hDEAD_BEEF, 2);
    rd_chk("err_status", 32'h4, 32'h9, 1);
    wr(32'h0, 32'h2);
    rd_chk("clr_status", 32'h4, 32'h1, 1);
    @(posedge clk); #1 ap_done = 1'b1; ap_ready = 1'b1;
    @(posedge clk); #1 ap_done = 1'b0; ap_ready = 1'b0; ap_idle = 1'b1;
    @(negedge clk);
    chk("done_ap_start", {31'd0, ap_start}, 32'd0);
    rd_chk("dropped_write", 32'h8000_0000, 32'hCAFE_0001, 2);
    rd_chk("done_status", 32'h4, 32'h6, 1);

    // Clear and ap_done in the same cycle
    ap_idle = 1'b0;
    wr(32'h0, 32'h1);
    wr(32'h0, 32'h1);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 32'h0; wdata = 32'h2; ap_done = 1'b1; ap_ready = 1'b1;
    @(negedge clk);
    chk("clrdone_ack", {31'd0, ack}, 32'd1);
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; ap_done = 1'b0; ap_ready = 1'b0; ap_idle = 1'b1;
    rd_chk("clrdone_status", 32'h4, 32'h6, 1);

    // Back-to-back reads with req held
    @(posedge clk); #1 req = 1'b1; we = 1'b0; addr = 32'h8000_0010;
    @(negedge clk); chk("b2b_ack0", {31'd0, ack}, 32'd1);
    @(posedge clk); #1 addr = 32'h9000_0000;
    @(negedge clk); chk("b2b_ack1", {31'd0, ack}, 32'd0);
    chk("b2b_noresp1", {31'd0, resp}, 32'd0);
    @(negedge clk); chk("b2b_resp2", {31'd0, resp}, 32'd1);
    chk("b2b_rdata2", rdata, 32'h1234_5678);
    chk("b2b_ack2", {31'd0, ack}, 32'd0);
    @(negedge clk); chk("b2b_ack3", {31'd0, ack}, 32'd1);
    chk("b2b_noresp3", {31'd0, resp}, 32'd0);
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk); chk("b2b_noresp4", {31'd0, resp}, 32'd0);
    @(negedge clk); chk("b2b_resp5", {31'd0, resp}, 32'd1);
    chk("b2b_rdata5", rdata, 32'h0000_0005);
    @(negedge clk); chk("b2b_noresp6", {31'd0, resp}, 32'd0);

    // Reset mid-run with a bank read in flight
    ap_idle = 1'b0;
    wr(32'h0, 32'h1);
    @(posedge clk); #1 req = 1'b1; we = 1'b0; addr = 32'h8000_0000;
    @(negedge clk); chk("rr_ack", {31'd0, ack}, 32'd1);
    @(posedge clk); #1 req = 1'b0; rstn = 1'b0;
    @(posedge clk); #1 ap_idle = 1'b1;
    @(negedge clk);
    chk("rr_noresp2", {31'd0, resp}, 32'd0);
    chk("rr_ap_start", {31'd0, ap_start}, 32'd0);
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk); chk("rr_noresp3", {31'd0, resp}, 32'd0);
    @(negedge clk); chk("rr_noresp4", {31'd0, resp}, 32'd0);
    rd_chk("rr_status", 32'h4, 32'h4, 1);
    rd_chk("rr_cycles", 32'h8, 32'h0, 1);
    rd_chk("rr_bank", 32'h8000_0010, 32'h1234_5678, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
